csb2falcon_fifo_ctrl: RTL and testbench
=======================================

Name: csb2falcon_fifo_ctrl

Overview:
Control block that sequences the 2x34 flop-RAM of the CSB-to-Falcon FIFO. It takes a valid/ready write handshake and a valid/ready read handshake, and generates the RAM-side strobes: iwe, we, wa and ra. The RAM data path is not part of this block. That path is a one-cycle input staging register (loaded on iwe), a write into the RAM array on the following cycle (we/wa), and a combinational read mux (ra). The block also provides clock-gate enable and idle status for the csb_master SLCG logic.

Parameters:
DEPTH, 2, number of RAM entries; power of two, legal values 2, 4, 8
AW, 1, address width, equal to log2(DEPTH)

Ports:
clk  input  1  core clock; the RAM-gated clock is derived from it
reset  input  1  asynchronous, active-high reset
wr_pvld  input  1  write request valid
wr_prdy  output  1  write ready
rd_pvld  output  1  read data valid; read data is the RAM dout
rd_prdy  input  1  read consumer ready
ram_iwe  output  1  load the input staging register
ram_we  output  1  write the staged data into the RAM array
ram_wa  output  AW  RAM write address
ram_ra  output  AW  RAM read address
ram_clk_en  output  1  enable for clk_mgated
wr_count  output  AW+1  entries accepted and not yet popped, including the staged entry
fifo_idle  output  1  FIFO empty and no write in flight

Behaviour:
- Definitions: wr_accept = wr_pvld & wr_prdy; rd_pop = rd_pvld & rd_prdy.
- Registers (all cleared asynchronously by reset): wr_count, rd_count (AW+1 bits each), wr_pending, wr_adr, rd_adr (AW bits each), wr_ready_r.
- Reset values of outputs: wr_prdy=0, rd_pvld=0, ram_iwe=0, ram_we=0, ram_wa=0, ram_ra=0, ram_clk_en=0, wr_count=0, fifo_idle=1.
- wr_ready_r:
  - Set on the first clk edge after reset deasserts.
  - Then tracks (wr_count_next < DEPTH).
  - wr_prdy = wr_ready_r, registered. There is no combinational path from wr_pvld or rd_prdy to wr_prdy.
- ram_iwe = wr_accept (combinational). Staged data is captured at the end of the accept cycle.
- wr_pending <= wr_accept every cycle.
- ram_we = wr_pending; ram_wa = wr_adr; wr_adr <= wr_adr+1 (mod DEPTH) when ram_we.
- Back-to-back writes sustain one per cycle. The RAM write at the end of cycle N+1 uses the staging value captured at the end of cycle N, while a new accept at cycle N+1 reloads the staging register at the same edge.
- wr_count_next = wr_count + wr_accept - rd_pop.
- rd_count_next = rd_count + ram_we - rd_pop.
- rd_pvld = (rd_count != 0), from registers only.
- ram_ra = rd_adr; rd_adr <= rd_adr+1 (mod DEPTH) on rd_pop.
- Latency: an accept in cycle N raises rd_pvld in cycle N+2 if the FIFO was empty. Read data is valid whenever rd_pvld=1.
- Full: wr_count==DEPTH gives wr_prdy=0 in the next cycle. A pop in the same cycle as the full condition does not bypass; wr_prdy rises the cycle after the pop.
- Empty: rd_count==0 gives rd_pvld=0. A staged-but-unwritten entry is never presented to the reader.
- Simultaneous accept and pop: wr_count unchanged; both pointers advance as specified.
- Pointers wrap modulo DEPTH with no extra state.
- ram_clk_en = ram_we, so the RAM clock toggles only on write cycles.
- fifo_idle = (wr_count==0) & ~wr_pending & ~wr_pvld.
- Reset mid-operation: all counters and pointers clear and queued entries are discarded. RAM and staging contents are not reset and are not visible because rd_pvld=0.
- Invariants (assertions):
  - rd_count <= wr_count <= DEPTH.
  - wr_count - rd_count == wr_pending.
  - rd_pop never occurs when rd_pvld=0.

Test Plan:
- Reset release, wr_pvld=0 -> cycle 0: wr_prdy=0, fifo_idle=1; cycle 1: wr_prdy=1; all RAM strobes stay 0.
- Single write at cycle N -> ram_iwe=1 at N; ram_we=1 with ram_wa=0 at N+1; rd_pvld=1 with ram_ra=0 at N+2; pop at N+2 -> rd_pvld=0 and wr_count=0 at N+3.
- Two back-to-back writes with rd_prdy=0 -> ram_we at N+1 (wa=0) and N+2 (wa=1); wr_count=2; wr_prdy=0 from N+2; third wr_pvld held and not accepted.
- Full FIFO with one pop at cycle M -> wr_prdy=1 at M+1; next write lands at wa=0 (wrap); read order returns the entries written at wa=1, then wa=0.
- Continuous write and read at one per cycle for 20 items -> steady-state wr_count toggles between 1 and 2; no drop or duplication; scoreboard order preserved; ram_clk_en high only on ram_we cycles.
- Reset asserted with wr_count=2 and a write pending -> all outputs return to reset values asynchronously; after release, a fresh write reads back at ra=0 with no stale rd_pvld.

Source files
------------

// File: rtl/csb2falcon_fifo_ctrl.sv
// csb2falcon_fifo_ctrl: sequences the staging register, write strobes and read pointer
// of the CSB-to-Falcon flop-RAM FIFO, plus SLCG clock-enable and idle status.
module csb2falcon_fifo_ctrl #(
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_pvld,
   output logic          wr_prdy,
   output logic          rd_pvld,
   input  logic          rd_prdy,
   output logic          ram_iwe,
   output logic          ram_we,
   output logic [AW-1:0] ram_wa,
   output logic [AW-1:0] ram_ra,
   output logic          ram_clk_en,
   output logic [AW:0]   wr_count,
   output logic          fifo_idle
);
   logic [AW:0]   wr_count_q, wr_count_d, rd_count_q, rd_count_d;
   logic [AW-1:0] wr_adr_q, rd_adr_q;
   logic          wr_pending_q, wr_ready_q, wr_accept, rd_pop;
   always_comb begin
      wr_accept  = wr_pvld & wr_ready_q;
      rd_pop     = rd_pvld & rd_prdy;
      wr_count_d = wr_count_q + (AW+1)'(wr_accept) - (AW+1)'(rd_pop);
      rd_count_d = rd_count_q + (AW+1)'(wr_pending_q) - (AW+1)'(rd_pop);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_count_q   <= '0;
         rd_count_q   <= '0;
         wr_adr_q     <= '0;
         rd_adr_q     <= '0;
         wr_pending_q <= 1'b0;
         wr_ready_q   <= 1'b0;
      end else begin
         wr_count_q   <= wr_count_d;
         rd_count_q   <= rd_count_d;
         wr_pending_q <= wr_accept;
         wr_ready_q   <= wr_count_d < (AW+1)'(DEPTH);
         if (wr_pending_q) wr_adr_q <= wr_adr_q + 1'b1;
         if (rd_pop) rd_adr_q <= rd_adr_q + 1'b1;
      end
   end
   // rd_count lags wr_count by exactly the one staged-but-unwritten entry
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (rd_count_q <= wr_count_q && wr_count_q <= (AW+1)'(DEPTH));
         assert (wr_count_q - rd_count_q == (AW+1)'(wr_pending_q));
         assert (!(rd_pop && !rd_pvld));
      end
   end
   assign wr_prdy    = wr_ready_q;
   assign rd_pvld    = rd_count_q != '0;
   assign ram_iwe    = wr_accept;
   assign ram_we     = wr_pending_q;
   assign ram_wa     = wr_adr_q;
   assign ram_ra     = rd_adr_q;
   assign ram_clk_en = wr_pending_q;
   assign wr_count   = wr_count_q;
   assign fifo_idle  = (wr_count_q == '0) & ~wr_pending_q & ~wr_pvld;
endmodule

// File: tb/tb_csb2falcon_fifo_ctrl.sv
// tb_csb2falcon_fifo_ctrl: directed vector table, async-reset sequence and randomized
// traffic checked against a queue-based model of the FIFO with a bench-side RAM image.
module tb_csb2falcon_fifo_ctrl;
   localparam int DEPTH = 2;
   localparam int AW    = 1;
   logic          clk = 1'b0, reset = 1'b1, wr_pvld = 1'b0, rd_prdy = 1'b0;
   logic          wr_prdy, rd_pvld, ram_iwe, ram_we, ram_clk_en, fifo_idle;
   logic [AW-1:0] ram_wa, ram_ra;
   logic [AW:0]   wr_count;
   int tests = 0, fails = 0;
   csb2falcon_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .wr_pvld(wr_pvld), .wr_prdy(wr_prdy),
      .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .ram_iwe(ram_iwe), .ram_we(ram_we),
      .ram_wa(ram_wa), .ram_ra(ram_ra), .ram_clk_en(ram_clk_en),
      .wr_count(wr_count), .fifo_idle(fifo_idle));
   always #5 clk = ~clk;
   int din, stage, mem [DEPTH];
   always @(posedge clk) begin
      if (ram_iwe) stage <= din;
      if (ram_we) mem[ram_wa] <= stage;
   end
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask
   typedef struct {int id; int acc; int slot;} ent_t;
   ent_t q[$];
   int cyc, nacc, npops;
   bit started;
   task automatic do_reset();
      reset = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      q.delete(); cyc = 0; nacc = 0; npops = 0; started = 1'b0;
   endtask
   task automatic mcycle(input bit wv, input bit rr);
      bit e_prdy, e_pvld, e_we, acc, pop;
      wr_pvld = wv; rd_prdy = rr; din = nacc + 100;
      @(negedge clk);
      e_prdy = started && q.size() < DEPTH;
      e_pvld = q.size() > 0 && q[0].acc <= cyc - 2;
      e_we   = q.size() > 0 && q[$].acc == cyc - 1;
      acc = wv && e_prdy;
      pop = e_pvld && rr;
      chk("wr_prdy", wr_prdy, e_prdy);
      chk("rd_pvld", rd_pvld, e_pvld);
      chk("ram_iwe", ram_iwe, acc);
      chk("ram_we", ram_we, e_we);
      chk("ram_clk_en", ram_clk_en, e_we);
      chk("wr_count", wr_count, q.size());
      chk("fifo_idle", fifo_idle, q.size() == 0 && !e_we && !wv);
      if (e_we) chk("ram_wa", ram_wa, q[$].slot);
      if (e_pvld) chk("ram_ra", ram_ra, q[0].slot);
      if (pop) chk("rd_data", mem[ram_ra], q[0].id);
      if (pop) begin void'(q.pop_front()); npops++; end
      if (acc) begin q.push_back('{nacc + 100, cyc, nacc % DEPTH}); nacc++; end
      cyc++; started = 1'b1;
      @(posedge clk);
      #1;
   endtask
   typedef struct {
      bit wv, rr, prdy, pvld, iwe, we;
      int wa, ra, cnt;
      bit idle;
   } vec_t;
   vec_t v[13];
   initial begin
      v[0]  = '{0,0, 0,0,0,0, 0,0,0, 1};
      v[1]  = '{1,0, 1,0,1,0, 0,0,0, 0};
      v[2]  = '{0,0, 1,0,0,1, 0,0,1, 0};
      v[3]  = '{0,1, 1,1,0,0, 1,0,1, 0};
      v[4]  = '{0,0, 1,0,0,0, 1,1,0, 1};
      v[5]  = '{1,0, 1,0,1,0, 1,1,0, 0};
      v[6]  = '{1,0, 1,0,1,1, 1,1,1, 0};
      v[7]  = '{1,0, 0,1,0,1, 0,1,2, 0};
      v[8]  = '{1,1, 0,1,0,0, 1,1,2, 0};
      v[9]  = '{1,0, 1,1,1,0, 1,0,1, 0};
      v[10] = '{0,1, 0,1,0,1, 1,0,2, 0};
      v[11] = '{0,1, 1,1,0,0, 0,1,1, 0};
      v[12] = '{0,0, 1,0,0,0, 0,0,0, 1};
      do_reset();
      for (int i = 0; i < 13; i++) begin
         wr_pvld = v[i].wv; rd_prdy = v[i].rr;
         @(negedge clk);
         chk($sformatf("v%0d.wr_prdy", i), wr_prdy, v[i].prdy);
         chk($sformatf("v%0d.rd_pvld", i), rd_pvld, v[i].pvld);
         chk($sformatf("v%0d.ram_iwe", i), ram_iwe, v[i].iwe);
         chk($sformatf("v%0d.ram_we", i), ram_we, v[i].we);
         chk($sformatf("v%0d.ram_clk_en", i), ram_clk_en, v[i].we);
         chk($sformatf("v%0d.ram_wa", i), ram_wa, v[i].wa);
         chk($sformatf("v%0d.ram_ra", i), ram_ra, v[i].ra);
         chk($sformatf("v%0d.wr_count", i), wr_count, v[i].cnt);
         chk($sformatf("v%0d.fifo_idle", i), fifo_idle, v[i].idle);
         @(posedge clk);
         #1;
      end
      // asynchronous reset with two entries held and one still staged
      do_reset();
      mcycle(0, 0); mcycle(1, 0); mcycle(1, 0);
      wr_pvld = 1'b0;
      #1;
      chk("pre_rst.wr_count", wr_count, 2);
      chk("pre_rst.ram_we", ram_we, 1);
      #1 reset = 1'b1;
      #1;
      chk("rst.wr_prdy", wr_prdy, 0);
      chk("rst.rd_pvld", rd_pvld, 0);
      chk("rst.ram_iwe", ram_iwe, 0);
      chk("rst.ram_we", ram_we, 0);
      chk("rst.ram_wa", ram_wa, 0);
      chk("rst.ram_ra", ram_ra, 0);
      chk("rst.ram_clk_en", ram_clk_en, 0);
      chk("rst.wr_count", wr_count, 0);
      chk("rst.fifo_idle", fifo_idle, 1);
      @(posedge clk);
      #1 reset = 1'b0;
      q.delete(); cyc = 0; nacc = 0; npops = 0; started = 1'b0;
      mcycle(0, 0); mcycle(1, 0);
      repeat (4) mcycle(0, 1);
      chk("post_rst.pops", npops, 1);
      // continuous stream of 20 items
      do_reset();
      for (int i = 0; i < 100 && npops < 20; i++) mcycle(nacc < 20, 1);
      chk("stream.pops", npops, 20);
      chk("stream.accepts", nacc, 20);
      // randomized traffic with varying write/read bias
      for (int s = 0; s < 4; s++) begin
         do_reset();
         for (int i = 0; i < 150; i++)
            mcycle(($urandom % 4) < s + 1, ($urandom % 4) < 4 - s);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
